// File: rtl/sobel_window_gen.sv
// Purpose : turns a raster-order grayscale pixel stream into 3x3 sobel_matrix windows, one per interior pixel.
// Latency : 1 cycle from pixel accept to matrix_valid_o; sustains one pixel per clock.
// Backpres: pixel_ready_o drops while a window is held unaccepted; matrix_o is frozen until matrix_ready_i.
//
// Ports:
//   clk_i, nreset_i              clock (rising edge) and asynchronous active-low reset
//   pixel_i/pixel_valid_i/sof_i  pixel stream in; sof_i marks the accepted pixel as position (0,0)
//   pixel_ready_o                input handshake, combinational from output-side state only
//   matrix_o/matrix_valid_o      3x3 window out, matrix_ready_i is the downstream handshake
//   frame_done_o                 one-cycle pulse after the last pixel of a frame is accepted

package sobel_pkg;
   localparam int SOBEL_PIXEL_WIDTH = 8;

   typedef logic [SOBEL_PIXEL_WIDTH-1:0] sobel_pixel;

   // One image line of the window: pix0 is the oldest column, pix2 the newest.
   typedef struct packed {
      sobel_pixel pix0;
      sobel_pixel pix1;
      sobel_pixel pix2;
   } sobel_vector;

   // vector0 is the top line (oldest), vector2 the bottom line (current).
   typedef struct packed {
      sobel_vector vector0;
      sobel_vector vector1;
      sobel_vector vector2;
   } sobel_matrix;
endpackage

module sobel_window_gen
   import sobel_pkg::*;
#(
   parameter int PIXEL_WIDTH = 8,   // must match SOBEL_PIXEL_WIDTH
   parameter int IMG_WIDTH   = 16,  // pixels per line, >= 3
   parameter int IMG_HEIGHT  = 16   // lines per frame, >= 3
) (
   input  logic                   clk_i,
   input  logic                   nreset_i,
   input  logic [PIXEL_WIDTH-1:0] pixel_i,
   input  logic                   pixel_valid_i,
   input  logic                   sof_i,
   output logic                   pixel_ready_o,
   output sobel_matrix            matrix_o,
   output logic                   matrix_valid_o,
   input  logic                   matrix_ready_i,
   output logic                   frame_done_o
);

   localparam int COL_W = $clog2(IMG_WIDTH);
   localparam int ROW_W = $clog2(IMG_HEIGHT);

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
   localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
   localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

   // ---------------------------------------------------------------
   // Position tracking
   // ---------------------------------------------------------------
   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   logic [COL_W-1:0] col_eff;
   logic [ROW_W-1:0] row_eff;
   logic             accept;
   logic             win_emit;
   logic             last_pixel;

   // The ready path only looks at the output register, so a stalled
   // consumer never forms a combinational loop with the producer.
   assign pixel_ready_o = !matrix_valid_o || matrix_ready_i;
   assign accept        = pixel_valid_i && pixel_ready_o;

   // sof_i restarts the frame at the pixel it arrives with.
   assign col_eff = sof_i ? '0 : col;
   assign row_eff = sof_i ? '0 : row;

   // A window is complete once two full lines and two columns of the
   // current line are behind it; this also flushes the stale columns left
   // in the shift window from the previous line.
   assign win_emit   = (row_eff >= ROW_TWO) && (col_eff >= COL_TWO);
   assign last_pixel = (row_eff == ROW_LAST) && (col_eff == COL_LAST);

   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         col <= '0;
         row <= '0;
      end else if (accept) begin
         if (col_eff == COL_LAST) begin
            col <= '0;
            row <= (row_eff == ROW_LAST) ? '0 : row_eff + 1'b1;
         end else begin
            col <= col_eff + 1'b1;
            row <= row_eff;
         end
      end
   end

   // ---------------------------------------------------------------
   // Line buffers: lb0 holds line r-2, lb1 holds line r-1 at each column.
   // Not reset; a column is always rewritten before its contents reach an
   // emitted window.
   // ---------------------------------------------------------------
   sobel_pixel lb0 [IMG_WIDTH];
   sobel_pixel lb1 [IMG_WIDTH];
   sobel_pixel lb_top;
   sobel_pixel lb_mid;

   assign lb_top = lb0[col_eff];
   assign lb_mid = lb1[col_eff];

   always_ff @(posedge clk_i) begin
      if (accept) begin
         lb0[col_eff] <= lb_mid;
         lb1[col_eff] <= sobel_pixel'(pixel_i);
      end
   end

   // ---------------------------------------------------------------
   // 3x3 shift window
   // ---------------------------------------------------------------
   sobel_matrix win;
   sobel_matrix win_next;

   always_comb begin
      win_next = win;
      win_next.vector0.pix0 = win.vector0.pix1;
      win_next.vector0.pix1 = win.vector0.pix2;
      win_next.vector0.pix2 = lb_top;
      win_next.vector1.pix0 = win.vector1.pix1;
      win_next.vector1.pix1 = win.vector1.pix2;
      win_next.vector1.pix2 = lb_mid;
      win_next.vector2.pix0 = win.vector2.pix1;
      win_next.vector2.pix1 = win.vector2.pix2;
      win_next.vector2.pix2 = sobel_pixel'(pixel_i);
   end

   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         win <= '0;
      end else if (accept) begin
         win <= win_next;
      end
   end

   // ---------------------------------------------------------------
   // Output register. A new window may replace one being drained in the
   // same cycle; otherwise valid falls once the consumer takes it. While
   // stalled, accept is low, so matrix_o cannot change.
   // ---------------------------------------------------------------
   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         matrix_o       <= '0;
         matrix_valid_o <= 1'b0;
      end else if (accept && win_emit) begin
         matrix_o       <= win_next;
         matrix_valid_o <= 1'b1;
      end else if (matrix_ready_i) begin
         matrix_valid_o <= 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         frame_done_o <= 1'b0;
      end else begin
         frame_done_o <= accept && last_pixel;
      end
   end

endmodule

// File: doc/sobel_window_gen.md
Name: sobel_window_gen

Overview:
Producer side of the sobel_matrix interface. It accepts a raster-order grayscale pixel stream and keeps two line buffers plus a 3x3 shift window. For every interior pixel position it presents one sobel_matrix to the downstream Sobel core. The block sits between the grayscale converter and the Sobel core, and uses valid/ready handshakes on both sides.

Parameters:
PIXEL_WIDTH, 8, bits per input grayscale pixel (must equal the pixel field width of sobel_matrix)
IMG_WIDTH, 16, pixels per line (>=3)
IMG_HEIGHT, 16, lines per frame (>=3)

Ports:
clk_i  in  1  clock; all state on rising edge
nreset_i  in  1  asynchronous active-low reset
pixel_i  in  PIXEL_WIDTH  input pixel, raster order
pixel_valid_i  in  1  pixel_i valid
sof_i  in  1  start-of-frame; qualifies the pixel accepted in the same cycle
pixel_ready_o  out  1  block accepts pixel this cycle
matrix_o  out  sobel_matrix  3x3 window (struct from parameters.svh)
matrix_valid_o  out  1  matrix_o valid
matrix_ready_i  in  1  downstream accepts matrix_o
frame_done_o  out  1  one-cycle pulse, last pixel of frame accepted

Behaviour:
- Single clock, clk_i. Reset is asynchronous and active-low on nreset_i.
- Reset values: col/row counters 0, window registers 0, matrix_o 0, matrix_valid_o 0, frame_done_o 0. Line buffers (2 x IMG_WIDTH x PIXEL_WIDTH) are not reset; their contents are never exposed before being rewritten.
- Ready: pixel_ready_o = !matrix_valid_o || matrix_ready_i. This is combinational and contains no path from pixel_valid_i.
- Accept: pixel_valid_i && pixel_ready_o. Only accepted pixels change state.
- Position: effective (r,c) = (0,0) if sof_i is set on accept, else (row,col).
- Line buffer read at effective column c: lb0[c] holds line r-2, lb1[c] holds line r-1.
- On accept:
  - lb0[c] <= lb1[c]; lb1[c] <= pixel_i.
  - Window shifts one column left.
  - New right column is {top=lb0[c], mid=lb1[c], bottom=pixel_i}.
- Window orientation:
  - vector0 = top line (r-2), vector1 = middle line (r-1), vector2 = bottom line (r).
  - pix0 = column c-2, pix1 = c-1, pix2 = c (newest).
  - Result: the x gradient is right minus left, the y gradient is bottom minus top.
- Output register:
  - If the accepted pixel has r>=2 && c>=2, then on the next edge matrix_o <= the shifted window and matrix_valid_o <= 1.
  - Otherwise, if matrix_ready_i, matrix_valid_o <= 0.
  - Latency: 1 cycle from accept to valid.
  - matrix_o is held stable while matrix_valid_o && !matrix_ready_i.
- Windows: no border padding. Output count is (IMG_WIDTH-2)*(IMG_HEIGHT-2) per frame. Columns stale from the previous line are flushed because validity requires c>=2.
- Counters after accept:
  - col <= c+1, wrapping to 0 at IMG_WIDTH-1.
  - On wrap, row <= r+1, wrapping to 0 at IMG_HEIGHT-1.
  - Counters are plain binary; widths are $clog2 of the parameter.
- frame_done_o: set on the edge after accepting (r,c) = (IMG_HEIGHT-1, IMG_WIDTH-1); cleared next cycle. Counters are then (0,0).
- sof_i mid-frame: abandons the current frame; that pixel becomes (0,0). No windows are produced until line 2 of the new frame, even though the line buffers hold old data.
- sof_i on a non-accepted cycle: ignored.
- Simultaneous output drain and new window: matrix_ready_i=1 with a new window → matrix_valid_o stays 1 and matrix_o updates. Full throughput is one pixel per clock.
- Reset mid-operation: all registers return to reset values immediately. A pending matrix is discarded and the next accepted pixel is (0,0).

Test Plan:
- 4x4 frame, pixel = 4r+c, matrix_ready_i=1, no stalls.
  - First valid one cycle after pixel 10: vector0={0,1,2}, vector1={4,5,6}, vector2={8,9,10}.
  - Then {1,2,3}/{5,6,7}/{9,10,11}.
  - Exactly 4 windows; frame_done_o pulses once, after pixel 15.
- Backpressure: hold matrix_ready_i=0 after first valid.
  - pixel_ready_o=0 and matrix_o stable for 5 cycles.
  - On release, remaining windows arrive in order with none lost or duplicated.
- Gapped input: random pixel_valid_i duty cycle 30%, 16x16 frame.
  - Exactly 196 windows, all matching a software 3x3 extraction.
- Back-to-back frames without sof_i: second frame's windows are correct.
  - Window count 4+4 for 4x4.
  - frame_done_o pulses twice.
- sof_i asserted at old-frame pixel 6.
  - No window until new-frame pixel 10.
  - New-frame windows are correct.
- nreset_i low mid-frame with matrix_valid_o=1.
  - matrix_valid_o=0 and matrix_o=0 immediately.
  - Subsequent frame is correct from pixel 0.
